// File: rtl/pc_sequencer.sv
// Fetch-stage next-PC controller: sequential/jump/branch/exception selection with stall-buffered redirect.
// Optional feature macro: PC_SEQ_EXCEPTION_EN enables the exception input (ignored when undefined).
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'd100,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        exception,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        flush_if,
  output logic        redirect_pending,
  output logic [15:0] redirect_count
);

  typedef enum logic {RUN, PEND} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] pend_tgt_q;
  logic        flush_q;
  logic [15:0] count_q;

  logic        exc_req;
  logic        req;
  logic [31:0] tgt_raw;
  logic [31:0] tgt;
  logic [15:0] count_d;

`ifdef PC_SEQ_EXCEPTION_EN
  assign exc_req = exception;
`else
  logic unused_exception;
  assign exc_req          = 1'b0;
  assign unused_exception = exception;
`endif

  assign req     = exc_req | branch_taken | jump;
  assign tgt_raw = exc_req ? EXC_VECTOR : (branch_taken ? branch_target : jump_target);
  // Fetch addresses are word aligned; low bits of any target are dropped.
  assign tgt     = {tgt_raw[31:2], 2'b00};
  assign count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      pend_tgt_q <= 32'd0;
      flush_q    <= 1'b0;
      count_q    <= 16'd0;
    end else begin
      flush_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (!stall) begin
            if (req) begin
              pc_q    <= tgt;
              flush_q <= 1'b1;
              count_q <= count_d;
            end else begin
              pc_q <= pc_q + 32'd4;
            end
          end else if (req) begin
            pend_tgt_q <= tgt;
            state_q    <= PEND;
          end
        end
        PEND: begin
          // Branch/jump seen here are wrong-path; only an exception may replace the buffered target.
          if (exc_req) begin
            pend_tgt_q <= EXC_VECTOR;
          end
          if (!stall) begin
            pc_q    <= exc_req ? EXC_VECTOR : pend_tgt_q;
            flush_q <= 1'b1;
            count_q <= count_d;
            state_q <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign pc               = pc_q;
  assign pc_plus4         = pc_q + 32'd4;
  assign flush_if         = flush_q;
  assign redirect_pending = (state_q == PEND);
  assign redirect_count   = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios, randomized traffic and count saturation.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC   = 32'd100;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_0180;
`ifdef PC_SEQ_EXCEPTION_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset, stall, branch_taken, jump, exception;
  logic [31:0] branch_target, jump_target;
  logic [31:0] pc, pc_plus4;
  logic        flush_if, redirect_pending;
  logic [15:0] redirect_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_tgt;
  bit          m_flush;
  int          m_cnt;

  pc_sequencer #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VECTOR)) dut (
    .clock(clock), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .exception(exception),
    .pc(pc), .pc_plus4(pc_plus4), .flush_if(flush_if),
    .redirect_pending(redirect_pending), .redirect_count(redirect_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply the architectural rules to the inputs present at this edge.
  task automatic model_edge();
    bit          e, req;
    logic [31:0] t;
    if (reset) begin
      m_pc = RESET_PC; m_pend = 0; m_tgt = 0; m_flush = 0; m_cnt = 0;
      return;
    end
    e   = EXC_EN && exception;
    req = e || branch_taken || jump;
    t   = e ? EXC_VECTOR : (branch_taken ? branch_target : jump_target);
    t   = t & ~32'd3;
    m_flush = 0;
    if (!m_pend) begin
      if (!stall && req) begin
        m_pc = t; m_flush = 1; m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      end else if (!stall) begin
        m_pc = m_pc + 32'd4;
      end else if (req) begin
        m_pend = 1; m_tgt = t;
      end
    end else begin
      if (e) m_tgt = EXC_VECTOR;
      if (!stall) begin
        m_pc = m_tgt; m_flush = 1; m_pend = 0;
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      end
    end
  endtask

  task automatic step(input bit do_chk);
    @(posedge clock);
    model_edge();
    #1;
    if (do_chk) begin
      chk("pc", pc, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("flush_if", {31'd0, flush_if}, {31'd0, m_flush});
      chk("redirect_pending", {31'd0, redirect_pending}, {31'd0, m_pend});
      chk("redirect_count", {16'd0, redirect_count}, m_cnt[31:0]);
      $display("t=%0t pc=%h flush=%0b pend=%0b cnt=%0d", $time, pc, flush_if, redirect_pending, redirect_count);
    end
  endtask

  task automatic idle();
    stall = 0; branch_taken = 0; jump = 0; exception = 0;
  endtask

  initial begin
    reset = 1; idle(); branch_target = 0; jump_target = 0;
    m_pc = 0; m_pend = 0; m_tgt = 0; m_flush = 0; m_cnt = 0;
    step(1); step(1);
    chk("reset_pc", pc, 32'd100);
    reset = 0;
    step(1); chk("seq_104", pc, 32'd104);
    step(1); chk("seq_108", pc, 32'd108);
    step(1); chk("seq_112", pc, 32'd112);
    step(1); chk("seq_116", pc, 32'd116);
    chk("seq_count0", {16'd0, redirect_count}, 32'd0);

    // Branch beats jump
    reset = 1; step(1); reset = 0;
    step(1); step(1); chk("at_108", pc, 32'd108);
    branch_taken = 1; branch_target = 32'h200; jump = 1; jump_target = 32'h300;
    step(1); chk("branch_prio", pc, 32'h200); chk("branch_flush", {31'd0, flush_if}, 32'd1);
    idle(); step(1); chk("flush_one_cycle", {31'd0, flush_if}, 32'd0);

    // Jump buffered across a stall; wrong-path branch ignored
    stall = 1; jump = 1; jump_target = 32'h403; step(1);
    jump = 0; branch_taken = 1; branch_target = 32'h600; step(1);
    branch_taken = 0; step(1);
    chk("stall_hold", pc, 32'h204); chk("stall_pending", {31'd0, redirect_pending}, 32'd1);
    stall = 0; step(1);
    chk("release_pc", pc, 32'h400); chk("release_flush", {31'd0, flush_if}, 32'd1);
    idle(); step(1);

    // Exception on release edge
    stall = 1; branch_taken = 1; branch_target = 32'h500; step(1);
    branch_taken = 0; stall = 0; exception = 1; step(1);
    chk("exc_release", pc, EXC_EN ? 32'h180 : 32'h500);
    idle(); step(1);

    // Wrap-around
    jump = 1; jump_target = 32'hFFFF_FFFC; step(1);
    idle(); step(1); chk("wrap_zero", pc, 32'd0);

    // Reset in PEND with stall
    stall = 1; jump = 1; jump_target = 32'h800; step(1);
    reset = 1; step(1);
    chk("rst_pend_pc", pc, 32'd100); chk("rst_pend_flag", {31'd0, redirect_pending}, 32'd0);
    reset = 0; idle(); step(1);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      reset         = ($urandom_range(0, 63) == 0);
      stall         = ($urandom_range(0, 9) < 4);
      branch_taken  = ($urandom_range(0, 9) < 2);
      jump          = ($urandom_range(0, 9) < 2);
      exception     = ($urandom_range(0, 19) == 0);
      branch_target = $urandom;
      jump_target   = $urandom;
      step(1);
    end

    // Count saturation: back-to-back redirects until the counter tops out
    reset = 1; idle(); step(1); reset = 0;
    jump = 1;
    for (int i = 0; i < 65535; i++) begin
      jump_target = $urandom;
      step(0);
    end
    chk("count_max", {16'd0, redirect_count}, 32'h0000_FFFF);
    step(1);
    chk("count_sat", {16'd0, redirect_count}, 32'h0000_FFFF);
    idle(); step(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
